// File: rtl/baud_tick_gen_frac_if.sv
// Control and tick bundle between a baud tick generator and its UART clients.
// The master side drives the rate/enable controls; the slave side returns the ticks.
interface baud_tick_gen_frac_if #(
    parameter int OVERSAMPLE = 16
);
    localparam int PW = $clog2(OVERSAMPLE);

    logic          en;
    logic          sync;
    logic [1:0]    baud_sel;
    logic          os_tick;
    logic          bit_tick;
    logic [PW-1:0] os_phase;

    modport master (
        output en, sync, baud_sel,
        input  os_tick, bit_tick, os_phase
    );

    modport slave (
        input  en, sync, baud_sel,
        output os_tick, bit_tick, os_phase
    );
endinterface

// File: rtl/baud_tick_gen_frac.sv
// Fractional phase-accumulator baud generator: oversample and bit ticks,
// four run-time selectable rates, enable and phase resync.
module baud_tick_gen_frac #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned BAUD0      = 9600,
    parameter int unsigned BAUD1      = 19200,
    parameter int unsigned BAUD2      = 57600,
    parameter int unsigned BAUD3      = 115200
) (
    input  logic                 clk,
    input  logic                 rst,
    baud_tick_gen_frac_if.slave  bus
);
    localparam int PW = $clog2(OVERSAMPLE);

    function automatic logic [63:0] inc_of(input logic [63:0] baud);
        logic [63:0] num;
        num = (baud * 64'(OVERSAMPLE)) << ACC_WIDTH;
        return (num + 64'(CLK_FREQ) / 64'd2) / 64'(CLK_FREQ);
    endfunction

    localparam logic [63:0] INC0_W  = inc_of(64'(BAUD0));
    localparam logic [63:0] INC1_W  = inc_of(64'(BAUD1));
    localparam logic [63:0] INC2_W  = inc_of(64'(BAUD2));
    localparam logic [63:0] INC3_W  = inc_of(64'(BAUD3));
    localparam logic [63:0] INC_MAX = 64'd1 << (ACC_WIDTH - 1);

    // Below half scale guarantees at most one carry per edge
    if (INC0_W == 64'd0 || INC0_W >= INC_MAX ||
        INC1_W == 64'd0 || INC1_W >= INC_MAX ||
        INC2_W == 64'd0 || INC2_W >= INC_MAX ||
        INC3_W == 64'd0 || INC3_W >= INC_MAX) begin : g_bad_inc
        $error("baud_tick_gen_frac: increment out of range");
    end

    if (OVERSAMPLE < 2 || OVERSAMPLE > 64 ||
        (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
        $error("baud_tick_gen_frac: OVERSAMPLE must be a power of 2 in 2..64");
    end

    localparam logic [ACC_WIDTH-1:0] INC0 = INC0_W[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] INC1 = INC1_W[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] INC2 = INC2_W[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] INC3 = INC3_W[ACC_WIDTH-1:0];
    localparam logic [PW-1:0]        CNT_LAST = PW'(OVERSAMPLE - 1);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [PW-1:0]        cnt_q, cnt_d;
    logic [1:0]           sel_q, sel_d;
    logic                 os_q, os_d;
    logic                 bit_q, bit_d;

    logic [ACC_WIDTH-1:0] inc;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;

    always_comb begin
        unique case (sel_q)
            2'd0: inc = INC0;
            2'd1: inc = INC1;
            2'd2: inc = INC2;
            2'd3: inc = INC3;
        endcase
    end

    assign sum   = {1'b0, acc_q} + {1'b0, inc};
    assign carry = sum[ACC_WIDTH];

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        sel_d = sel_q;
        os_d  = 1'b0;
        bit_d = 1'b0;
        if (bus.sync) begin
            acc_d = '0;
            cnt_d = '0;
            sel_d = bus.baud_sel;
        end else if (bus.baud_sel != sel_q) begin
            // New rate starts from a clean phase on the following edge
            acc_d = '0;
            cnt_d = '0;
            sel_d = bus.baud_sel;
        end else if (bus.en) begin
            acc_d = sum[ACC_WIDTH-1:0];
            if (carry) begin
                os_d  = 1'b1;
                bit_d = (cnt_q == CNT_LAST);
                cnt_d = cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            sel_q <= bus.baud_sel;
            os_q  <= 1'b0;
            bit_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            os_q  <= os_d;
            bit_q <= bit_d;
        end
    end

    assign bus.os_tick  = os_q;
    assign bus.bit_tick = bit_q;
    assign bus.os_phase = cnt_q;
endmodule

// File: tb/tb_baud_tick_gen_frac.sv
// Directed bench for baud_tick_gen_frac at default parameters:
// per-rate measurement table plus resync, rate-change, enable-gap and reset sequences.
module tb_baud_tick_gen_frac;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    baud_tick_gen_frac_if #(.OVERSAMPLE(16)) bus ();

    baud_tick_gen_frac dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] sel;
        int         cycles;
        int         first;
        int         imin;
        int         imax;
        int         ticks;
        int         bits;
        int         bmin;
        int         bmax;
    } vec_t;

    vec_t tbl[4];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input longint act,
                           input longint lo, input longint hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int lim, output int n);
        n = -1;
        for (int k = 1; k <= lim; k++) begin
            step();
            if (bus.os_tick) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic run_row(input int r, input vec_t v);
        int first, last, imin, imax, ticks, bits, lastb, bmin, bmax, viol;
        int ph;
        first = -1; last = -1; imin = 1 << 30; imax = 0;
        ticks = 0; bits = 0; lastb = -1; bmin = 1 << 30; bmax = 0;
        viol = 0; ph = 0;
        bus.baud_sel = v.sel;
        bus.en       = 1'b1;
        bus.sync     = 1'b0;
        rst          = 1'b0;
        step();
        rst = 1'b1;
        chk($sformatf("row%0d reset state", r),
            {bus.os_tick, bus.bit_tick, bus.os_phase}, 0);
        for (int k = 1; k <= v.cycles; k++) begin
            step();
            if (bus.bit_tick && !bus.os_tick) viol++;
            if (bus.os_tick) begin
                ticks++;
                ph = (ph + 1) % 16;
                if (int'(bus.os_phase) != ph) viol++;
                if (bus.bit_tick != (ph == 0)) viol++;
                if (first < 0) first = k;
                else begin
                    if (k - last < imin) imin = k - last;
                    if (k - last > imax) imax = k - last;
                end
                last = k;
                if (bus.bit_tick) begin
                    bits++;
                    if (lastb >= 0) begin
                        if (k - lastb < bmin) bmin = k - lastb;
                        if (k - lastb > bmax) bmax = k - lastb;
                    end
                    lastb = k;
                end
            end else if (int'(bus.os_phase) != ph) viol++;
        end
        chk($sformatf("row%0d first os_tick edge", r), first, v.first);
        chk($sformatf("row%0d os_tick count", r), ticks, v.ticks);
        chk($sformatf("row%0d bit_tick count", r), bits, v.bits);
        chk_rng($sformatf("row%0d min interval", r), imin, v.imin, v.imax);
        chk_rng($sformatf("row%0d max interval", r), imax, v.imin, v.imax);
        chk($sformatf("row%0d phase/bit violations", r), viol, 0);
        chk_rng($sformatf("row%0d min bit interval", r), bmin, v.bmin, v.bmax);
        chk_rng($sformatf("row%0d max bit interval", r), bmax, v.bmin, v.bmax);
    endtask

    initial begin
        int n, cnt, idx, bad;
        bit found;
        logic [3:0] ph_save;

        tbl[0] = '{2'd0, 24000, 652, 651, 652,  36,  2, 10416, 10417};
        tbl[1] = '{2'd1, 12000, 326, 325, 326,  36,  2,  5208,  5209};
        tbl[2] = '{2'd2, 10000, 109, 108, 109,  92,  5,  1736,  1737};
        tbl[3] = '{2'd3, 12000,  55,  54,  55, 221, 13,   868,   869};

        bus.en = 1'b0;
        bus.sync = 1'b0;
        bus.baud_sel = 2'd0;
        step();
        step();

        for (int r = 0; r < 4; r++) run_row(r, tbl[r]);

        // Rate change 0 -> 3 mid-bit
        bus.baud_sel = 2'd0;
        bus.en = 1'b1;
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 0; k < 5000; k++) step();
        chk("pre-change os_phase", bus.os_phase, 7);
        bus.baud_sel = 2'd3;
        step();
        chk("change edge os_tick", bus.os_tick, 0);
        chk("change edge os_phase", bus.os_phase, 0);
        wait_tick(200, n);
        chk("post-change first os_tick", n, 55);

        // Sync at os_phase 7
        found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (bus.os_phase == 4'd7) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("reached os_phase 7", found, 1);
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        chk("sync os_phase", bus.os_phase, 0);
        chk("sync os_tick", bus.os_tick, 0);
        idx = -1;
        cnt = 0;
        for (int k = 1; k <= 1000; k++) begin
            step();
            if (bus.os_tick) cnt++;
            if (bus.bit_tick) begin
                idx = k;
                break;
            end
        end
        chk("sync first bit_tick edge", idx, 869);
        chk("sync os_ticks to bit_tick", cnt, 16);

        // Enable gap mid-count
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (bus.os_tick) cnt++;
        end
        chk("pre-gap os_ticks", cnt, 1);
        ph_save = bus.os_phase;
        bus.en = 1'b0;
        bad = 0;
        for (int k = 0; k < 500; k++) begin
            step();
            if (bus.os_tick || bus.bit_tick || bus.os_phase != ph_save) bad++;
        end
        chk("gap activity", bad, 0);
        bus.en = 1'b1;
        wait_tick(100, n);
        chk("resume to 2nd os_tick", n, 9);
        wait_tick(100, n);
        chk("resume to 3rd os_tick", n, 54);

        // Reset with sync and rate change together
        chk("pre-reset os_phase", bus.os_phase, 3);
        rst = 1'b0;
        bus.sync = 1'b1;
        bus.baud_sel = 2'd1;
        step();
        chk("combined reset os_tick", bus.os_tick, 0);
        chk("combined reset bit_tick", bus.bit_tick, 0);
        chk("combined reset os_phase", bus.os_phase, 0);
        rst = 1'b1;
        bus.sync = 1'b0;
        wait_tick(400, n);
        chk("post-reset first os_tick", n, 326);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
